// File: rtl/rx_pkg.sv
// Shared definitions for the QAM16 receiver carrier-recovery supervisor:
// FSM state encoding, loop-filter gain codes and default widths.
package rx_pkg;

   typedef enum logic [1:0] {
      ST_ACQ    = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } lock_state_t;

   localparam logic [1:0] GAIN_WIDE   = 2'b00;
   localparam logic [1:0] GAIN_MEDIUM = 2'b01;
   localparam logic [1:0] GAIN_NARROW = 2'b10;

   localparam int W_DEFAULT = 27;

endpackage

// File: rtl/abs_window_acc.sv
// Saturating |pd| followed by a fixed-length window integrator; publishes the
// window sum on err_mag together with a one-cycle win_done pulse.
module abs_window_acc
   import rx_pkg::*;
#(
   parameter int W        = W_DEFAULT,
   parameter int WIN_LOG2 = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic signed [W-1:0]     pd,
   output logic                    win_done,
   output logic [W+WIN_LOG2-1:0]   err_mag
);

   localparam int MW = W + WIN_LOG2;

   logic [W-2:0]        mag;
   logic [MW-1:0]       acc;
   logic [MW-1:0]       sum;
   logic [WIN_LOG2-1:0] cnt;

   // The most negative code has no positive twin; clamp it to full scale.
   always_comb begin
      mag = pd[W-2:0];
      if (pd[W-1]) begin
         if (pd[W-2:0] == '0) begin
            mag = '1;
         end else begin
            mag = (W-1)'(-pd);
         end
      end
      sum = acc + MW'(mag);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc      <= '0;
         cnt      <= '0;
         win_done <= 1'b0;
         err_mag  <= '0;
      end else begin
         win_done <= 1'b0;
         if (en) begin
            cnt <= cnt + WIN_LOG2'(1);
            if (cnt == '1) begin
               err_mag  <= sum;
               acc      <= '0;
               win_done <= 1'b1;
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule

// File: rtl/carrier_lock_ctrl.sv
// Carrier-lock supervisor: classifies each integrated |pd| window and walks an
// acquire/verify/locked FSM that drives loop gain, lock flag and NCO clear.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_ACQ    | wide loop gain; waiting for a good window, NCO clear on timeout
//   ST_VERIFY | medium gain; counting consecutive good windows
//   ST_LOCKED | narrow gain, lock=1; consecutive bad windows drop back to ACQ
module carrier_lock_ctrl
   import rx_pkg::*;
#(
   parameter int                W           = W_DEFAULT,
   parameter int                WIN_LOG2    = 10,
   parameter longint unsigned   LOCK_TH     = 64'd1073741824,
   parameter longint unsigned   UNLOCK_TH   = 64'd2147483648,
   parameter int                LOCK_CNT    = 4,
   parameter int                UNLOCK_CNT  = 2,
   parameter int                ACQ_TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic signed [W-1:0]     pd,
   output logic                    lock,
   output logic [1:0]              gain_sel,
   output logic                    nco_clr,
   output logic                    win_done,
   output logic [W+WIN_LOG2-1:0]   err_mag
);

   localparam int MW = W + WIN_LOG2;
   localparam int AW = $clog2(ACQ_TIMEOUT + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);

   localparam logic [MW-1:0] LOCK_TH_M   = MW'(LOCK_TH);
   localparam logic [MW-1:0] UNLOCK_TH_M = MW'(UNLOCK_TH);
   localparam logic [AW-1:0] ACQ_MAX     = AW'(ACQ_TIMEOUT);
   localparam logic [GW-1:0] GOOD_MAX    = GW'(LOCK_CNT);
   localparam logic [BW-1:0] BAD_MAX     = BW'(UNLOCK_CNT);

   lock_state_t   state, state_n;
   logic [AW-1:0] acq_cnt, acq_n;
   logic [GW-1:0] good_cnt, good_n;
   logic [BW-1:0] bad_cnt, bad_n;
   logic          nco_n;
   logic          good, bad;

   abs_window_acc #(
      .W        (W),
      .WIN_LOG2 (WIN_LOG2)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pd       (pd),
      .win_done (win_done),
      .err_mag  (err_mag)
   );

   assign good = (err_mag < LOCK_TH_M);
   assign bad  = (err_mag > UNLOCK_TH_M);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_ACQ;
         acq_cnt  <= '0;
         good_cnt <= '0;
         bad_cnt  <= '0;
         nco_clr  <= 1'b0;
      end else begin
         state    <= state_n;
         acq_cnt  <= acq_n;
         good_cnt <= good_n;
         bad_cnt  <= bad_n;
         nco_clr  <= nco_n;
      end
   end

   always_comb begin
      state_n = state;
      acq_n   = acq_cnt;
      good_n  = good_cnt;
      bad_n   = bad_cnt;
      nco_n   = 1'b0;
      if (win_done) begin
         case (state)
            ST_ACQ: begin
               if (good) begin
                  state_n = ST_VERIFY;
                  good_n  = GW'(1);
                  acq_n   = '0;
               end else if (acq_cnt + AW'(1) == ACQ_MAX) begin
                  nco_n = 1'b1;
                  acq_n = '0;
               end else begin
                  acq_n = acq_cnt + AW'(1);
               end
            end
            ST_VERIFY: begin
               // The entry window is counted in good_cnt; lock needs LOCK_CNT
               // further good windows observed while in VERIFY.
               if (!good) begin
                  state_n = ST_ACQ;
                  good_n  = '0;
                  acq_n   = '0;
               end else if (good_cnt == GOOD_MAX) begin
                  state_n = ST_LOCKED;
                  good_n  = '0;
                  bad_n   = '0;
               end else begin
                  good_n = good_cnt + GW'(1);
               end
            end
            ST_LOCKED: begin
               if (bad) begin
                  if (bad_cnt + BW'(1) == BAD_MAX) begin
                     state_n = ST_ACQ;
                     bad_n   = '0;
                     acq_n   = '0;
                  end else begin
                     bad_n = bad_cnt + BW'(1);
                  end
               end else begin
                  bad_n = '0;
               end
            end
            default: begin
               state_n = ST_ACQ;
            end
         endcase
      end
   end

   always_comb begin
      gain_sel = GAIN_WIDE;
      lock     = 1'b0;
      case (state)
         ST_VERIFY: gain_sel = GAIN_MEDIUM;
         ST_LOCKED: begin
            gain_sel = GAIN_NARROW;
            lock     = 1'b1;
         end
         default: gain_sel = GAIN_WIDE;
      endcase
   end

endmodule

// File: tb/tb_carrier_lock_ctrl.sv
// Directed bench for carrier_lock_ctrl with a 16-sample window: one table row
// per window, plus hand sequences for reset behaviour.
module tb_carrier_lock_ctrl;

   localparam int W  = 27;
   localparam int WL = 4;
   localparam int MW = W + WL;
   localparam int NV = 20;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic signed [W-1:0]  pd;
   logic                 lock;
   logic [1:0]           gain_sel;
   logic                 nco_clr;
   logic                 win_done;
   logic [MW-1:0]        err_mag;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic signed [W-1:0] pd;
      int                  period;
      logic [MW-1:0]       mag;
      logic [1:0]          gain;
      logic                lk;
      logic                nco;
   } vec_t;

   vec_t vec [NV];

   carrier_lock_ctrl #(
      .W           (W),
      .WIN_LOG2    (WL),
      .LOCK_TH     (64'd160),
      .UNLOCK_TH   (64'd320),
      .LOCK_CNT    (3),
      .UNLOCK_CNT  (2),
      .ACQ_TIMEOUT (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pd       (pd),
      .lock     (lock),
      .gain_sel (gain_sel),
      .nco_clr  (nco_clr),
      .win_done (win_done),
      .err_mag  (err_mag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic e, input logic signed [W-1:0] p);
      en = e;
      pd = p;
      @(negedge clk);
   endtask

   // One full window: gap cycles carry en=0 with a large pd that must be ignored.
   task automatic run_window(input int idx, input logic signed [W-1:0] p, input int period,
                             input logic [MW-1:0] em, input logic [1:0] eg,
                             input logic el, input logic enco);
      int early;
      early = 0;
      for (int s = 0; s < 16; s++) begin
         for (int g = 1; g < period; g++) begin
            step(1'b0, 27'sd1000);
            if (win_done) early++;
         end
         step(1'b1, p);
         if (s < 15 && win_done) early++;
      end
      check("early_win_done", idx, 64'(early), 64'd0);
      check("win_done", idx, 64'(win_done), 64'd1);
      check("err_mag", idx, 64'(err_mag), 64'(em));
      check("nco_on_wd", idx, 64'(nco_clr), 64'd0);
      step(1'b0, 27'sd1000);
      check("gain_sel", idx, 64'(gain_sel), 64'(eg));
      check("lock", idx, 64'(lock), 64'(el));
      check("nco_clr", idx, 64'(nco_clr), 64'(enco));
      check("win_done_pulse", idx, 64'(win_done), 64'd0);
      step(1'b0, 27'sd1000);
      check("nco_second", idx, 64'(nco_clr), 64'd0);
   endtask

   initial begin
      vec[0]  = '{27'sd5,       1, 31'd80,         2'b01, 1'b0, 1'b0};
      vec[1]  = '{27'sd5,       1, 31'd80,         2'b01, 1'b0, 1'b0};
      vec[2]  = '{27'sd5,       1, 31'd80,         2'b01, 1'b0, 1'b0};
      vec[3]  = '{27'sd5,       1, 31'd80,         2'b10, 1'b1, 1'b0};
      vec[4]  = '{-27'sd30,     1, 31'd480,        2'b10, 1'b1, 1'b0};
      vec[5]  = '{27'sd20,      1, 31'd320,        2'b10, 1'b1, 1'b0};
      vec[6]  = '{-27'sd30,     1, 31'd480,        2'b10, 1'b1, 1'b0};
      vec[7]  = '{-27'sd30,     1, 31'd480,        2'b00, 1'b0, 1'b0};
      vec[8]  = '{27'sd100,     1, 31'd1600,       2'b00, 1'b0, 1'b0};
      vec[9]  = '{27'sd100,     1, 31'd1600,       2'b00, 1'b0, 1'b0};
      vec[10] = '{27'sd100,     1, 31'd1600,       2'b00, 1'b0, 1'b0};
      vec[11] = '{27'sd100,     1, 31'd1600,       2'b00, 1'b0, 1'b1};
      vec[12] = '{27'sd100,     1, 31'd1600,       2'b00, 1'b0, 1'b0};
      vec[13] = '{27'sh4000000, 1, 31'd1073741808, 2'b00, 1'b0, 1'b0};
      vec[14] = '{27'sd5,       1, 31'd80,         2'b01, 1'b0, 1'b0};
      vec[15] = '{27'sd10,      1, 31'd160,        2'b00, 1'b0, 1'b0};
      vec[16] = '{27'sd9,       1, 31'd144,        2'b01, 1'b0, 1'b0};
      vec[17] = '{27'sd5,       3, 31'd80,         2'b01, 1'b0, 1'b0};
      vec[18] = '{27'sd5,       3, 31'd80,         2'b01, 1'b0, 1'b0};
      vec[19] = '{27'sd5,       2, 31'd80,         2'b10, 1'b1, 1'b0};

      rst = 1'b0;
      en  = 1'b0;
      pd  = '0;
      repeat (3) step(1'($urandom), W'($urandom));
      check("rst_lock", 0, 64'(lock), 64'd0);
      check("rst_gain", 0, 64'(gain_sel), 64'd0);
      check("rst_nco", 0, 64'(nco_clr), 64'd0);
      check("rst_win_done", 0, 64'(win_done), 64'd0);
      check("rst_err_mag", 0, 64'(err_mag), 64'd0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_window(i, vec[i].pd, vec[i].period, vec[i].mag, vec[i].gain, vec[i].lk,
                    vec[i].nco);
      end

      // Reset in the middle of a window while locked: partial sum must be dropped.
      repeat (10) step(1'b1, 27'sd7);
      rst = 1'b0;
      step(1'b1, 27'sd500);
      check("midrst_lock", 1, 64'(lock), 64'd0);
      check("midrst_gain", 1, 64'(gain_sel), 64'd0);
      check("midrst_err_mag", 1, 64'(err_mag), 64'd0);
      check("midrst_win_done", 1, 64'(win_done), 64'd0);
      rst = 1'b1;
      run_window(100, 27'sd5, 1, 31'd80, 2'b01, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
